// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port main RAM: CPU and DMA requesters each
// get a fixed WAIT-cycle access window, round-robin on ties, one-cycle ack.
module mem_arbiter #(
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 16,
  parameter int unsigned WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_be,
  input  logic [DW-1:0] ram_rdata,
  output logic          gnt_cpu,
  output logic          gnt_dma
);

  localparam int unsigned CW       = 4;
  localparam logic        LAST_CPU = 1'b0;
  localparam logic        LAST_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;
  logic [AW-1:0] ram_addr_nxt;
  logic [DW-1:0] ram_wdata_nxt, cpu_rdata_nxt, dma_rdata_nxt;
  logic          ram_we_nxt, ram_be_nxt;
  logic          gnt_cpu_nxt, gnt_dma_nxt, cpu_ack_nxt, dma_ack_nxt;
  logic          pick_cpu, pick_dma;

  // Round-robin: on a tie the port not served last wins.
  assign pick_cpu  = cpu_req & (~dma_req | (last == LAST_DMA));
  assign pick_dma  = dma_req & ~pick_cpu;
  assign cpu_stall = cpu_req & ~cpu_ack;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= LAST_DMA;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_be    <= 1'b0;
      gnt_cpu   <= 1'b0;
      gnt_dma   <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_wdata <= ram_wdata_nxt;
      ram_we    <= ram_we_nxt;
      ram_be    <= ram_be_nxt;
      gnt_cpu   <= gnt_cpu_nxt;
      gnt_dma   <= gnt_dma_nxt;
      cpu_ack   <= cpu_ack_nxt;
      dma_ack   <= dma_ack_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      dma_rdata <= dma_rdata_nxt;
    end
  end

  // Next-state logic; DONE never arbitrates so requesters can drop req.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cpu_req | dma_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    cnt_nxt       = cnt;
    last_nxt      = last;
    ram_addr_nxt  = ram_addr;
    ram_wdata_nxt = ram_wdata;
    ram_we_nxt    = ram_we;
    ram_be_nxt    = ram_be;
    gnt_cpu_nxt   = gnt_cpu;
    gnt_dma_nxt   = gnt_dma;
    cpu_rdata_nxt = cpu_rdata;
    dma_rdata_nxt = dma_rdata;
    cpu_ack_nxt   = 1'b0;
    dma_ack_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_cpu) begin
          ram_addr_nxt  = cpu_addr;
          ram_wdata_nxt = cpu_wdata;
          ram_we_nxt    = cpu_we;
          ram_be_nxt    = cpu_be;
          gnt_cpu_nxt   = 1'b1;
          cnt_nxt       = CW'(WAIT - 1);
        end else if (pick_dma) begin
          ram_addr_nxt  = dma_addr;
          ram_wdata_nxt = dma_wdata;
          ram_we_nxt    = dma_we;
          ram_be_nxt    = 1'b0;
          gnt_dma_nxt   = 1'b1;
          cnt_nxt       = CW'(WAIT - 1);
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          if (gnt_cpu) begin
            cpu_ack_nxt = 1'b1;
            last_nxt    = LAST_CPU;
            if (!ram_we) cpu_rdata_nxt = ram_rdata;
          end else begin
            dma_ack_nxt = 1'b1;
            last_nxt    = LAST_DMA;
            if (!ram_we) dma_rdata_nxt = ram_rdata;
          end
          ram_we_nxt  = 1'b0;
          gnt_cpu_nxt = 1'b0;
          gnt_dma_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT=1 and WAIT=3) checked every
// cycle against a transaction-timeline model, plus directed scenario checks.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cpu_req[2], cpu_we[2], cpu_be[2], dma_req[2], dma_we[2];
  logic [15:0] cpu_addr[2], cpu_wdata[2], dma_addr[2], dma_wdata[2], ram_rdata[2];
  logic [15:0] cpu_rdata[2], dma_rdata[2], ram_addr[2], ram_wdata[2];
  logic        cpu_ack[2], cpu_stall[2], dma_ack[2], ram_we[2], ram_be[2];
  logic        gnt_cpu[2], gnt_dma[2];

  int passed = 0;
  int checks = 0;
  int fails  = 0;

  mem_arbiter #(.AW(16), .DW(16), .WAIT(1)) u_w1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_be(cpu_be[0]),
    .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]),
    .cpu_ack(cpu_ack[0]), .cpu_stall(cpu_stall[0]),
    .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_addr(dma_addr[0]),
    .dma_wdata(dma_wdata[0]), .dma_rdata(dma_rdata[0]), .dma_ack(dma_ack[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_we(ram_we[0]),
    .ram_be(ram_be[0]), .ram_rdata(ram_rdata[0]),
    .gnt_cpu(gnt_cpu[0]), .gnt_dma(gnt_dma[0])
  );

  mem_arbiter #(.AW(16), .DW(16), .WAIT(3)) u_w3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_be(cpu_be[1]),
    .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]),
    .cpu_ack(cpu_ack[1]), .cpu_stall(cpu_stall[1]),
    .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_addr(dma_addr[1]),
    .dma_wdata(dma_wdata[1]), .dma_rdata(dma_rdata[1]), .dma_ack(dma_ack[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_we(ram_we[1]),
    .ram_be(ram_be[1]), .ram_rdata(ram_rdata[1]),
    .gnt_cpu(gnt_cpu[1]), .gnt_dma(gnt_dma[1])
  );

  function automatic int wof(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // RAM contents as a pure function of address
  function automatic logic [15:0] ram_f(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : ((a ^ 16'hC3A5) + 16'h0101);
  endfunction

  function automatic logic win_dma(input logic c, input logic d, input logic last_was_dma);
    return d & (~c | ~last_was_dma);
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) ram_rdata[k] = ram_f(ram_addr[k]);
  end

  // Reference: el = cycles since the grant edge (0 = free, W+1 = ack cycle)
  int          el[2];
  logic        own[2], lastd[2], l_we[2], l_be[2];
  logic [15:0] l_addr[2], l_wdata[2], m_crd[2], m_drd[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        el[k] <= 0; own[k] <= 1'b0; lastd[k] <= 1'b1;
        l_we[k] <= 1'b0; l_be[k] <= 1'b0; l_addr[k] <= '0; l_wdata[k] <= '0;
        m_crd[k] <= '0; m_drd[k] <= '0;
      end else if (el[k] == 0) begin
        if (cpu_req[k] | dma_req[k]) begin
          own[k]     <= win_dma(cpu_req[k], dma_req[k], lastd[k]);
          l_addr[k]  <= win_dma(cpu_req[k], dma_req[k], lastd[k]) ? dma_addr[k] : cpu_addr[k];
          l_wdata[k] <= win_dma(cpu_req[k], dma_req[k], lastd[k]) ? dma_wdata[k] : cpu_wdata[k];
          l_we[k]    <= win_dma(cpu_req[k], dma_req[k], lastd[k]) ? dma_we[k] : cpu_we[k];
          l_be[k]    <= win_dma(cpu_req[k], dma_req[k], lastd[k]) ? 1'b0 : cpu_be[k];
          el[k]      <= 1;
        end
      end else if (el[k] == wof(k)) begin
        if (!l_we[k]) begin
          if (own[k]) m_drd[k] <= ram_f(l_addr[k]);
          else        m_crd[k] <= ram_f(l_addr[k]);
        end
        lastd[k] <= own[k];
        el[k]    <= el[k] + 1;
      end else if (el[k] > wof(k)) begin
        el[k] <= 0;
      end else begin
        el[k] <= el[k] + 1;
      end
    end
  end

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic check_dut(input int k);
    logic act, dn, eca;
    act = (el[k] >= 1) && (el[k] <= wof(k));
    dn  = (el[k] == wof(k) + 1);
    eca = dn & ~own[k];
    chk("gnt_cpu",   k, 32'(gnt_cpu[k]),   32'(act & ~own[k]));
    chk("gnt_dma",   k, 32'(gnt_dma[k]),   32'(act & own[k]));
    chk("ram_we",    k, 32'(ram_we[k]),    32'(act & l_we[k]));
    chk("ram_be",    k, 32'(ram_be[k]),    32'(l_be[k]));
    chk("ram_addr",  k, 32'(ram_addr[k]),  32'(l_addr[k]));
    chk("ram_wdata", k, 32'(ram_wdata[k]), 32'(l_wdata[k]));
    chk("cpu_ack",   k, 32'(cpu_ack[k]),   32'(eca));
    chk("dma_ack",   k, 32'(dma_ack[k]),   32'(dn & own[k]));
    chk("cpu_rdata", k, 32'(cpu_rdata[k]), 32'(m_crd[k]));
    chk("dma_rdata", k, 32'(dma_rdata[k]), 32'(m_drd[k]));
    chk("cpu_stall", k, 32'(cpu_stall[k]), 32'(cpu_req[k] & ~eca));
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_dut(k);
  endtask

  // One request held until its ack; returns latency, write cycles, grant cycles
  task automatic xfer(input int k, input logic dma, input logic we,
                      input logic [15:0] addr, input logic [15:0] wdata,
                      output int lat, output int wec, output int gnc);
    logic seen;
    lat = 0; wec = 0; gnc = 0; seen = 1'b0;
    if (dma) begin
      dma_we[k] = we; dma_addr[k] = addr; dma_wdata[k] = wdata; dma_req[k] = 1'b1;
    end else begin
      cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wdata; cpu_be[k] = 1'b0;
      cpu_req[k] = 1'b1;
    end
    while (!seen && lat < 40) begin
      step();
      lat++;
      if (ram_we[k]) wec++;
      if (gnt_cpu[k] | gnt_dma[k]) gnc++;
      seen = dma ? dma_ack[k] : cpu_ack[k];
    end
    chk("ack_seen", k, 32'(seen), 32'd1);
    if (dma) dma_req[k] = 1'b0;
    else     cpu_req[k] = 1'b0;
  endtask

  int lat, wec, gnc, na, cnt_a, cnt_g;
  int acyc[4];
  logic awho[4];

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_be[k] = 1'b0;
      cpu_addr[k] = '0; cpu_wdata[k] = '0;
      dma_req[k] = 1'b0; dma_we[k] = 1'b0; dma_addr[k] = '0; dma_wdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    step();
    reset = 1'b0;
    step();

    // CPU read, WAIT=1
    xfer(0, 1'b0, 1'b0, 16'h0010, 16'h0000, lat, wec, gnc);
    chk("t1_latency", 0, 32'(lat), 32'd2);
    chk("t1_gnt_cycles", 0, 32'(gnc), 32'd1);
    chk("t1_rdata", 0, 32'(cpu_rdata[0]), 32'h0000BEEF);
    step();

    // DMA write, WAIT=3
    xfer(1, 1'b1, 1'b1, 16'h0100, 16'h1234, lat, wec, gnc);
    chk("t2_latency", 1, 32'(lat), 32'd4);
    chk("t2_we_cycles", 1, 32'(wec), 32'd3);
    chk("t2_dma_rdata", 1, 32'(dma_rdata[1]), 32'd0);
    step();

    // Both requesting continuously from reset, WAIT=3
    reset = 1'b1; step(); reset = 1'b0;
    cpu_addr[1] = 16'h0020; dma_addr[1] = 16'h0030; cpu_we[1] = 1'b0; dma_we[1] = 1'b0;
    cpu_req[1] = 1'b1; dma_req[1] = 1'b1;
    na = 0;
    for (int c = 0; c < 60 && na < 4; c++) begin
      step();
      if (cpu_ack[1] | dma_ack[1]) begin
        acyc[na] = c; awho[na] = dma_ack[1]; na++;
      end
    end
    cpu_req[1] = 1'b0; dma_req[1] = 1'b0;
    chk("t3_ack_count", 1, 32'(na), 32'd4);
    chk("t3_first_ack", 1, 32'(acyc[0]), 32'd3);
    for (int i = 0; i < 4; i++) chk("t3_order", i, 32'(awho[i]), 32'(i % 2));
    for (int i = 1; i < 4; i++) chk("t3_spacing", i, 32'(acyc[i] - acyc[i-1]), 32'd5);
    step();

    // CPU drops req during ACCESS
    cpu_addr[1] = 16'h0044; cpu_req[1] = 1'b1;
    cnt_a = 0; cnt_g = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 1) cpu_req[1] = 1'b0;
      if (cpu_ack[1]) cnt_a++;
      if (gnt_cpu[1]) cnt_g++;
    end
    chk("t4_acks", 1, 32'(cnt_a), 32'd1);
    chk("t4_gnt_cycles", 1, 32'(cnt_g), 32'd3);

    // Reset in the 2nd ACCESS cycle of a DMA write (CPU served last before)
    xfer(1, 1'b0, 1'b0, 16'h0050, 16'h0000, lat, wec, gnc);
    step();
    dma_we[1] = 1'b1; dma_addr[1] = 16'h0060; dma_wdata[1] = 16'hA5A5; dma_req[1] = 1'b1;
    step(); step();
    dma_req[1] = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_ram_we", 1, 32'(ram_we[1]), 32'd0);
    chk("t5_gnt_dma", 1, 32'(gnt_dma[1]), 32'd0);
    cnt_a = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (cpu_ack[1] | dma_ack[1]) cnt_a++;
    end
    chk("t5_no_ack", 1, 32'(cnt_a), 32'd0);
    cpu_we[1] = 1'b0; dma_we[1] = 1'b0; cpu_req[1] = 1'b1; dma_req[1] = 1'b1;
    step();
    dma_req[1] = 1'b0;
    chk("t5_first_gnt_cpu", 1, 32'(gnt_cpu[1]), 32'd1);
    cnt_a = 0;
    for (int c = 0; c < 10 && cnt_a == 0; c++) begin
      step();
      if (cpu_ack[1]) cnt_a++;
    end
    cpu_req[1] = 1'b0;
    chk("t5_cpu_done", 1, 32'(cnt_a), 32'd1);
    step();

    // CPU back-to-back, WAIT=1
    cpu_addr[0] = 16'h0070; cpu_we[0] = 1'b0; cpu_req[0] = 1'b1;
    na = 0;
    for (int c = 0; c < 30 && na < 2; c++) begin
      step();
      if (cpu_ack[0]) begin acyc[na] = c; na++; end
    end
    cpu_req[0] = 1'b0;
    chk("t6_acks", 0, 32'(na), 32'd2);
    chk("t6_spacing", 0, 32'(acyc[1] - acyc[0]), 32'd3);
    step();

    // Randomized traffic on both instances
    for (int c = 0; c < 600; c++) begin
      step();
      reset = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < 2; k++) begin
        cpu_we[k] = 1'($urandom); cpu_be[k] = 1'($urandom);
        dma_we[k] = 1'($urandom);
        cpu_addr[k] = 16'($urandom); cpu_wdata[k] = 16'($urandom);
        dma_addr[k] = 16'($urandom); dma_wdata[k] = 16'($urandom);
        if (!cpu_req[k])                    cpu_req[k] = ($urandom_range(0, 2) == 0);
        else if (cpu_ack[k])                cpu_req[k] = 1'($urandom);
        else if ($urandom_range(0, 19) == 0) cpu_req[k] = 1'b0;
        if (!dma_req[k])                    dma_req[k] = ($urandom_range(0, 2) == 0);
        else if (dma_ack[k])                dma_req[k] = 1'($urandom);
        else if ($urandom_range(0, 19) == 0) dma_req[k] = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
